mem_bus_arbiter: RTL and testbench

- Shares the single external memory port between two requesters.
  - CPU port: multi-cycle controller; `cpu_ready` drives its `mio_ready` input.
  - DMA port: bootloader/debug port.
- Round-robin arbitration, one transaction at a time, registered outputs toward memory, per-access wait-state timeout.
- Sits between the CPU datapath/controller, the DMA loader and the memory wrapper.

---
 rtl/mem_bus_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one external memory port between a CPU requester and a DMA
// (bootloader/debug) requester. Arbitration is round-robin, one transaction is
// in flight at a time, every output is registered, and each access has a
// wait-state timeout that completes it with ERR_DATA if memory never answers.
//
// Ports
//   clk, reset                    rising-edge clock, async active-high reset
//   cpu_req/we/addr/wdata         CPU request (held until cpu_ready)
//   cpu_rdata, cpu_ready          CPU read data (held) and 1-cycle done pulse
//   dma_req/we/addr/wdata         DMA request
//   dma_rdata, dma_ready          DMA read data (held) and 1-cycle done pulse
//   mem_req/we/addr/wdata         memory request, held until mem_ack
//   mem_rdata, mem_ack            memory read data and completion
//   grant                         current owner: 00 none, 01 CPU, 10 DMA
//   timeout                       sticky flag, set by any expired access
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int            AW       = 32,
    parameter int            DW       = 32,
    parameter int            MAX_WAIT = 15,
    parameter logic [DW-1:0] ERR_DATA = DW'(32'hDEADBEEF)
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ready,

    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_ready,

    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,

    output logic [1:0]    grant,
    output logic          timeout
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_BUSY = 2'd1,
        DMA_BUSY = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_t     state_q, state_d;
    logic       last_dma;     // 1 when the DMA port owned the previous access
    logic [7:0] wait_cnt;     // ack-less BUSY cycles of the current access

    logic start_cpu, start_dma, finish, expired;
    logic busy;

    assign busy = (state_q == CPU_BUSY) || (state_q == DMA_BUSY);

    // Next-state decode plus the strobes the datapath register block acts on.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no path
        // leaves a signal unassigned, which would infer a latch.
        state_d   = state_q;
        start_cpu = 1'b0;
        start_dma = 1'b0;
        finish    = 1'b0;
        expired   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // On a tie the port that did not own the last access wins.
                if (cpu_req && (!dma_req || last_dma)) begin
                    start_cpu = 1'b1;
                    state_d   = CPU_BUSY;
                end else if (dma_req) begin
                    start_dma = 1'b1;
                    state_d   = DMA_BUSY;
                end
            end
            CPU_BUSY, DMA_BUSY: begin
                // An ack in the same cycle the counter hits the limit wins.
                if (mem_ack) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    finish  = 1'b1;
                    expired = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Registered outputs toward memory and both requesters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            grant     <= 2'b00;
            cpu_ready <= 1'b0;
            dma_ready <= 1'b0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
            timeout   <= 1'b0;
            wait_cnt  <= '0;
            last_dma  <= 1'b1;   // CPU wins the first tie after reset
        end else begin
            cpu_ready <= 1'b0;
            dma_ready <= 1'b0;

            if (start_cpu) begin
                mem_req   <= 1'b1;
                mem_we    <= cpu_we;
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
                grant     <= 2'b01;
                last_dma  <= 1'b0;
                wait_cnt  <= '0;
            end

            if (start_dma) begin
                mem_req   <= 1'b1;
                mem_we    <= dma_we;
                mem_addr  <= dma_addr;
                mem_wdata <= dma_wdata;
                grant     <= 2'b10;
                last_dma  <= 1'b1;
                wait_cnt  <= '0;
            end

            if (busy && !finish) wait_cnt <= wait_cnt + 8'd1;

            if (finish) begin
                mem_req <= 1'b0;
                // Writes leave the owner's read-data register untouched.
                if (state_q == CPU_BUSY) begin
                    cpu_ready <= 1'b1;
                    if (!mem_we) cpu_rdata <= expired ? ERR_DATA : mem_rdata;
                end else begin
                    dma_ready <= 1'b1;
                    if (!mem_we) dma_rdata <= expired ? ERR_DATA : mem_rdata;
                end
                if (expired) timeout <= 1'b1;
            end

            if (state_q == DONE) grant <= 2'b00;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Self-checking bench for mem_bus_arbiter. Directed scenarios cover reset,
// single accesses, tie-breaking and alternation, wait states, timeout, the
// ack-at-limit corner and reset mid-transaction. A randomized run compares the
// DUT every cycle against a transaction-level model of the arbitration rules.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int          AW       = 32;
    localparam int          DW       = 32;
    localparam int          MAX_WAIT = 15;
    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

    logic          clk;
    logic          reset;
    logic          cpu_req, cpu_we, dma_req, dma_we;
    logic [AW-1:0] cpu_addr, dma_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata;
    logic          cpu_ready, dma_ready;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [1:0]    grant;
    logic          timeout;

    int compared   = 0;
    int mismatched = 0;

    mem_bus_arbiter #(
        .AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .ERR_DATA(ERR_DATA)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ready(dma_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .grant(grant), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        mem_ack = 0; mem_rdata = '0;
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset;
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        compared++; if (mem_req !== 1'b0) begin mismatched++; $display("FAIL rst_mem_req: got %b expected 0", mem_req); end
        compared++; if (grant !== 2'b00) begin mismatched++; $display("FAIL rst_grant: got %b expected 00", grant); end
        compared++; if ({cpu_ready, dma_ready, timeout} !== 3'b000) begin mismatched++; $display("FAIL rst_flags: got %b expected 000", {cpu_ready, dma_ready, timeout}); end
        compared++; if (cpu_rdata !== 32'h0 || dma_rdata !== 32'h0) begin mismatched++; $display("FAIL rst_rdata: got %h/%h expected 0/0", cpu_rdata, dma_rdata); end
        compared++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_we !== 1'b0) begin mismatched++; $display("FAIL rst_mem_bus: got %h/%h/%b expected zeros", mem_addr, mem_wdata, mem_we); end
        reset = 1'b0;
        tick();
        compared++; if (mem_req !== 1'b0 || grant !== 2'b00) begin mismatched++; $display("FAIL rst_idle: got req %b grant %b expected 0 00", mem_req, grant); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_cpu_read;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;           // cycle 0
        tick();                                                  // cycle 1
        compared++; if (mem_req !== 1'b1) begin mismatched++; $display("FAIL cpu_rd_mem_req_c1: got %b expected 1", mem_req); end
        compared++; if (grant !== 2'b01) begin mismatched++; $display("FAIL cpu_rd_grant_c1: got %b expected 01", grant); end
        compared++; if (mem_addr !== 32'h100 || mem_we !== 1'b0) begin mismatched++; $display("FAIL cpu_rd_bus_c1: got %h/%b expected 00000100/0", mem_addr, mem_we); end
        compared++; if (cpu_ready !== 1'b0) begin mismatched++; $display("FAIL cpu_rd_ready_c1: got %b expected 0", cpu_ready); end
        mem_ack = 1; mem_rdata = 32'h12345678;
        tick();                                                  // cycle 2
        compared++; if (mem_req !== 1'b0) begin mismatched++; $display("FAIL cpu_rd_mem_req_c2: got %b expected 0", mem_req); end
        compared++; if (cpu_ready !== 1'b1 || dma_ready !== 1'b0) begin mismatched++; $display("FAIL cpu_rd_ready_c2: got %b/%b expected 1/0", cpu_ready, dma_ready); end
        compared++; if (cpu_rdata !== 32'h12345678) begin mismatched++; $display("FAIL cpu_rd_data: got %h expected 12345678", cpu_rdata); end
        compared++; if (grant !== 2'b01) begin mismatched++; $display("FAIL cpu_rd_grant_c2: got %b expected 01", grant); end
        mem_ack = 0; mem_rdata = '0; cpu_req = 0;
        tick();                                                  // cycle 3
        compared++; if (cpu_ready !== 1'b0 || grant !== 2'b00) begin mismatched++; $display("FAIL cpu_rd_c3: got ready %b grant %b expected 0 00", cpu_ready, grant); end
        compared++; if (cpu_rdata !== 32'h12345678) begin mismatched++; $display("FAIL cpu_rd_hold: got %h expected 12345678", cpu_rdata); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_tie_alternation;
        logic [1:0] exp_g [6];
        exp_g = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
        apply_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        dma_req = 1; dma_we = 0; dma_addr = 32'h20;
        for (int i = 0; i < 6; i++) begin
            tick();
            compared++; if (grant !== exp_g[i]) begin mismatched++; $display("FAIL tie_grant[%0d]: got %b expected %b", i, grant, exp_g[i]); end
            mem_ack = 0;
            if (i == 0) begin
                compared++; if (mem_addr !== 32'h10) begin mismatched++; $display("FAIL tie_cpu_addr: got %h expected 00000010", mem_addr); end
                mem_ack = 1; mem_rdata = 32'hA000_0010;
            end
            if (i == 1) begin
                compared++; if (cpu_rdata !== 32'hA000_0010) begin mismatched++; $display("FAIL tie_cpu_rdata: got %h expected a0000010", cpu_rdata); end
                cpu_req = 0;
            end
            if (i == 3) begin
                compared++; if (mem_addr !== 32'h20) begin mismatched++; $display("FAIL tie_dma_addr: got %h expected 00000020", mem_addr); end
                mem_ack = 1; mem_rdata = 32'hA000_0020;
            end
            if (i == 4) begin
                compared++; if (dma_rdata !== 32'hA000_0020) begin mismatched++; $display("FAIL tie_dma_rdata: got %h expected a0000020", dma_rdata); end
                dma_req = 0;
            end
        end
        // Both held continuously: ownership must alternate, CPU first.
        cpu_req = 1; dma_req = 1;
        for (int t = 0; t < 6; t++) begin
            tick();
            compared++; if (grant !== ((t % 2 == 0) ? 2'b01 : 2'b10)) begin mismatched++; $display("FAIL alt_grant[%0d]: got %b expected %b", t, grant, (t % 2 == 0) ? 2'b01 : 2'b10); end
            mem_ack = 1; mem_rdata = 32'hB000_0000 + 32'(t);
            tick();
            mem_ack = 0;
            compared++; if ({cpu_ready, dma_ready} !== ((t % 2 == 0) ? 2'b10 : 2'b01)) begin mismatched++; $display("FAIL alt_ready[%0d]: got %b expected %b", t, {cpu_ready, dma_ready}, (t % 2 == 0) ? 2'b10 : 2'b01); end
            tick();
        end
        cpu_req = 0; dma_req = 0;
        compared++; if (dma_rdata !== 32'hB000_0005 || cpu_rdata !== 32'hB000_0004) begin mismatched++; $display("FAIL alt_rdata: got %h/%h expected b0000004/b0000005", cpu_rdata, dma_rdata); end
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_dma_write_wait;
        dma_req = 1; dma_we = 1; dma_addr = 32'h40; dma_wdata = 32'hCAFEF00D;
        tick();
        for (int w = 0; w < 5; w++) begin
            compared++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin mismatched++; $display("FAIL dmaw_req_we[%0d]: got %b/%b expected 1/1", w, mem_req, mem_we); end
            compared++; if (mem_addr !== 32'h40 || mem_wdata !== 32'hCAFEF00D) begin mismatched++; $display("FAIL dmaw_bus[%0d]: got %h/%h expected 00000040/cafef00d", w, mem_addr, mem_wdata); end
            compared++; if (dma_ready !== 1'b0) begin mismatched++; $display("FAIL dmaw_early_ready[%0d]: got %b expected 0", w, dma_ready); end
            // Requester inputs move around; the bus must not follow.
            dma_addr = $urandom; dma_wdata = $urandom; dma_we = 0; dma_req = 0;
            tick();
        end
        compared++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin mismatched++; $display("FAIL dmaw_still_busy: got %b/%h expected 1/00000040", mem_req, mem_addr); end
        mem_ack = 1; mem_rdata = 32'hFFFF_0000;
        tick();
        mem_ack = 0;
        compared++; if (dma_ready !== 1'b1 || cpu_ready !== 1'b0) begin mismatched++; $display("FAIL dmaw_ready: got %b/%b expected 1/0", dma_ready, cpu_ready); end
        compared++; if (dma_rdata !== 32'hB000_0005) begin mismatched++; $display("FAIL dmaw_rdata_kept: got %h expected b0000005", dma_rdata); end
        tick();
        compared++; if (dma_ready !== 1'b0 || grant !== 2'b00) begin mismatched++; $display("FAIL dmaw_after: got ready %b grant %b expected 0 00", dma_ready, grant); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_timeout;
        int n;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h80;
        tick();
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        compared++; if (n !== MAX_WAIT + 1) begin mismatched++; $display("FAIL to_busy_cycles: got %0d expected %0d", n, MAX_WAIT + 1); end
        compared++; if (cpu_ready !== 1'b1) begin mismatched++; $display("FAIL to_ready: got %b expected 1", cpu_ready); end
        compared++; if (cpu_rdata !== ERR_DATA) begin mismatched++; $display("FAIL to_rdata: got %h expected %h", cpu_rdata, ERR_DATA); end
        compared++; if (timeout !== 1'b1) begin mismatched++; $display("FAIL to_flag: got %b expected 1", timeout); end
        // Stray acks outside an access must have no effect.
        cpu_req = 0; mem_ack = 1;
        tick();
        compared++; if (cpu_ready !== 1'b0 || grant !== 2'b00) begin mismatched++; $display("FAIL to_after: got ready %b grant %b expected 0 00", cpu_ready, grant); end
        tick();
        compared++; if (mem_req !== 1'b0 || grant !== 2'b00) begin mismatched++; $display("FAIL stray_ack: got req %b grant %b expected 0 00", mem_req, grant); end
        mem_ack = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h84; cpu_wdata = 32'h1;
        tick();
        mem_ack = 1; mem_rdata = 32'h7777_7777;
        tick();
        mem_ack = 0; cpu_req = 0;
        compared++; if (cpu_ready !== 1'b1 || cpu_rdata !== ERR_DATA) begin mismatched++; $display("FAIL to_write_ok: got %b/%h expected 1/%h", cpu_ready, cpu_rdata, ERR_DATA); end
        tick();
        compared++; if (timeout !== 1'b1) begin mismatched++; $display("FAIL to_sticky: got %b expected 1", timeout); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_ack_at_limit;
        apply_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'hC0;
        tick();
        for (int k = 0; k < MAX_WAIT; k++) tick();
        compared++; if (mem_req !== 1'b1) begin mismatched++; $display("FAIL lim_still_busy: got %b expected 1", mem_req); end
        mem_ack = 1; mem_rdata = 32'h5A5A_1234;
        tick();
        mem_ack = 0; cpu_req = 0;
        compared++; if (cpu_ready !== 1'b1 || cpu_rdata !== 32'h5A5A_1234) begin mismatched++; $display("FAIL lim_data: got %b/%h expected 1/5a5a1234", cpu_ready, cpu_rdata); end
        compared++; if (timeout !== 1'b0) begin mismatched++; $display("FAIL lim_no_timeout: got %b expected 0", timeout); end
        tick();
        compared++; if (timeout !== 1'b0) begin mismatched++; $display("FAIL lim_no_timeout_after: got %b expected 0", timeout); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid_txn;
        dma_req = 1; dma_we = 0; dma_addr = 32'h60;
        tick();
        compared++; if (grant !== 2'b10 || mem_req !== 1'b1) begin mismatched++; $display("FAIL rmid_busy: got grant %b req %b expected 10 1", grant, mem_req); end
        #2 reset = 1'b1;
        #1;
        compared++; if (mem_req !== 1'b0 || grant !== 2'b00 || dma_ready !== 1'b0) begin mismatched++; $display("FAIL rmid_async: got req %b grant %b ready %b expected 0 00 0", mem_req, grant, dma_ready); end
        @(negedge clk);
        compared++; if (mem_addr !== 32'h0 || mem_req !== 1'b0) begin mismatched++; $display("FAIL rmid_held: got addr %h req %b expected 0 0", mem_addr, mem_req); end
        reset = 1'b0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h70; dma_req = 1;
        tick();
        compared++; if (grant !== 2'b01 || mem_addr !== 32'h70) begin mismatched++; $display("FAIL rmid_cpu_first: got grant %b addr %h expected 01 00000070", grant, mem_addr); end
        mem_ack = 1;
        tick();
        clear_inputs();
        tick();
    endtask

    // ------------------------------------------------------------------
    // role 0: free requester (holds a pending request, may start a new one)
    // role 1: current owner mid-access (inputs may change arbitrarily)
    // role 2: owner just completed (presents a fresh request or none)
    task automatic drive_port(input bit is_dma, input int role);
        logic cur;
        cur = is_dma ? dma_req : cpu_req;
        if (role == 0 && cur) return;
        if (is_dma) begin
            dma_req   = (role == 1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 2) != 0);
            dma_we    = 1'($urandom_range(0, 1));
            dma_addr  = $urandom;
            dma_wdata = $urandom;
        end else begin
            cpu_req   = (role == 1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 2) != 0);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = $urandom;
            cpu_wdata = $urandom;
        end
    endtask

    task automatic test_random;
        int          phase;     // 0 no owner, 1 access in flight, 2 completion cycle
        int          owner;     // 0 CPU, 1 DMA
        int          k, lat, r;
        logic        last_dma, exp_to, t_we;
        logic [31:0] t_addr, t_wdata, exp_crd, exp_drd;
        logic [1:0]  exp_grant;
        apply_reset();
        phase = 0; owner = 0; k = 0; lat = 0;
        last_dma = 1; exp_to = 0; t_we = 0;
        t_addr = '0; t_wdata = '0; exp_crd = '0; exp_drd = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            exp_grant = (phase == 0) ? 2'b00 : ((owner == 1) ? 2'b10 : 2'b01);
            compared++; if (mem_req !== (phase == 1)) begin mismatched++; $display("FAIL rnd_mem_req cyc %0d: got %b expected %b", cyc, mem_req, phase == 1); end
            compared++; if (grant !== exp_grant) begin mismatched++; $display("FAIL rnd_grant cyc %0d: got %b expected %b", cyc, grant, exp_grant); end
            compared++; if ({cpu_ready, dma_ready} !== {phase == 2 && owner == 0, phase == 2 && owner == 1}) begin mismatched++; $display("FAIL rnd_ready cyc %0d: got %b expected %b", cyc, {cpu_ready, dma_ready}, {phase == 2 && owner == 0, phase == 2 && owner == 1}); end
            compared++; if (cpu_rdata !== exp_crd || dma_rdata !== exp_drd) begin mismatched++; $display("FAIL rnd_rdata cyc %0d: got %h/%h expected %h/%h", cyc, cpu_rdata, dma_rdata, exp_crd, exp_drd); end
            compared++; if (timeout !== exp_to) begin mismatched++; $display("FAIL rnd_timeout cyc %0d: got %b expected %b", cyc, timeout, exp_to); end
            if (phase == 1) begin
                compared++; if (mem_we !== t_we || mem_addr !== t_addr || mem_wdata !== t_wdata) begin mismatched++; $display("FAIL rnd_bus cyc %0d: got %b/%h/%h expected %b/%h/%h", cyc, mem_we, mem_addr, mem_wdata, t_we, t_addr, t_wdata); end
            end

            if (phase == 0) begin
                drive_port(0, 0); drive_port(1, 0);
                mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
                if (cpu_req || dma_req) begin
                    owner   = (cpu_req && (!dma_req || last_dma)) ? 0 : 1;
                    t_we    = owner ? dma_we    : cpu_we;
                    t_addr  = owner ? dma_addr  : cpu_addr;
                    t_wdata = owner ? dma_wdata : cpu_wdata;
                    last_dma = (owner == 1);
                    k = 0;
                    r = $urandom_range(0, 9);
                    if (r < 6)       lat = $urandom_range(0, 3);
                    else if (r < 8)  lat = $urandom_range(4, MAX_WAIT - 1);
                    else if (r == 8) lat = MAX_WAIT;
                    else             lat = MAX_WAIT + 1 + $urandom_range(0, 5);
                    phase = 1;
                end
            end else if (phase == 1) begin
                drive_port(0, (owner == 0) ? 1 : 0);
                drive_port(1, (owner == 1) ? 1 : 0);
                mem_rdata = $urandom;
                mem_ack   = (k == lat);
                if (k == lat) begin
                    if (!t_we) begin
                        if (owner == 0) exp_crd = mem_rdata; else exp_drd = mem_rdata;
                    end
                    phase = 2;
                end else if (k == MAX_WAIT) begin
                    if (!t_we) begin
                        if (owner == 0) exp_crd = ERR_DATA; else exp_drd = ERR_DATA;
                    end
                    exp_to = 1;
                    phase  = 2;
                end else begin
                    k++;
                end
            end else begin
                drive_port(0, (owner == 0) ? 2 : 0);
                drive_port(1, (owner == 1) ? 2 : 0);
                mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
                phase = 0;
            end
            tick();
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        test_reset();
        test_cpu_read();
        test_tie_alternation();
        test_dma_write_wait();
        test_timeout();
        test_ack_at_limit();
        test_reset_mid_txn();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
